// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline control blocks.
//  - Tuse / Tnew encodings and register-index types.
//  - REG_ZERO: the hard-wired zero register, which never carries a hazard.
//  - MD_MULT_LAT / MD_DIV_LAT: default mult/div unit latencies, shared with the md unit.
//  - reg_hazard(): one operand-vs-producer RAW comparison.
package pipe_pkg;

  typedef logic [4:0] reg_addr_t;
  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  // Tuse = 3 means the operand is not read; it can never be below any 2-bit Tnew.
  localparam tuse_t     TUSE_NONE = 2'd3;
  localparam reg_addr_t REG_ZERO  = 5'd0;

  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;

  // True when the D operand names a register that the producer writes, and the
  // producer's result will not be forwardable by the time D needs the operand.
  function automatic logic reg_hazard(input reg_addr_t rd_addr,
                                      input tuse_t     tuse,
                                      input reg_addr_t wr_addr,
                                      input tnew_t     tnew);
    return (rd_addr != REG_ZERO) && (rd_addr == wr_addr) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: busy countdown for the multi-cycle mult/div unit.
//  Ports:
//   clk     in   clock
//   reset   in   synchronous, active-high reset (clears the counter)
//   start   in   an md operation launches in E this cycle
//   is_div  in   the launched operation is a divide (else a multiply)
//   busy    out  counter nonzero, or a start this cycle
//  A start is only honoured while the counter is idle; a start that arrives
//  while counting is ignored and the countdown continues undisturbed.
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (start && (cnt_q == '0)) begin
      cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Busy already in the start cycle so the md instruction right behind it in D waits.
  assign busy = (cnt_q != '0) || start;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard / stall controller for the 5-stage pipeline.
//  Compares D-stage operand demand (Tuse) with E/M-stage result supply (Tnew)
//  and tracks the mult/div unit through md_busy_timer. On a stall the PC and D
//  registers hold and a bubble is loaded into E; M and W always advance.
//  Ports:
//   clk, reset                 clock, synchronous active-high reset
//   d_rs_addr/d_rt_addr        D operand register indices
//   d_tuse_rs/d_tuse_rt        cycles until D needs each operand (3 = unused)
//   d_is_md                    D instruction uses the md unit
//   e_wr_addr/e_tnew           E destination and cycles until forwardable
//   m_wr_addr/m_tnew           M destination and cycles until forwardable
//   e_md_start/e_md_is_div     E launches a mult (is_div=0) or div this cycle
//   f_we/d_we                  PC and D register write-enables
//   e_flush                    load a bubble into the E register
//   md_busy                    md unit busy
//   stall_cnt                  saturating count of stall cycles
//  Build option: define PIPE_STALL_STATS_EN to add the stall_cnt port and counter.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_wr_addr,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wr_addr,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  output logic        f_we,
  output logic        d_we,
  output logic        e_flush,
  output logic        md_busy
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic md_busy_w;
  logic hz_rs_e, hz_rs_m, hz_rt_e, hz_rt_m;
  logic md_stall;
  logic stall;

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_is_div),
    .busy   (md_busy_w)
  );

  always_comb begin
    hz_rs_e  = reg_hazard(d_rs_addr, d_tuse_rs, e_wr_addr, e_tnew);
    hz_rs_m  = reg_hazard(d_rs_addr, d_tuse_rs, m_wr_addr, m_tnew);
    hz_rt_e  = reg_hazard(d_rt_addr, d_tuse_rt, e_wr_addr, e_tnew);
    hz_rt_m  = reg_hazard(d_rt_addr, d_tuse_rt, m_wr_addr, m_tnew);
    md_stall = d_is_md && md_busy_w;
    stall    = hz_rs_e || hz_rs_m || hz_rt_e || hz_rt_m || md_stall;

    f_we     = ~stall;
    d_we     = ~stall;
    e_flush  = stall;
    md_busy  = md_busy_w;
  end

`ifdef PIPE_STALL_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: self-checking bench for pipe_stall_ctrl.
//  Inputs change on the falling edge and outputs are compared 1 ns later;
//  state advances on the rising edge. A table of single-cycle hazard vectors,
//  hand-written multi-cycle sequences (load-use, mult/div busy, reset mid-divide,
//  stall statistics) and a randomized run against a reference model.
//  Build option: PIPE_STALL_STATS_EN enables the stall_cnt checks.
module tb_pipe_stall_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs_addr, d_rt_addr, e_wr_addr, m_wr_addr;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_is_md, e_md_start, e_md_is_div;
  logic       f_we, d_we, e_flush, md_busy;
`ifdef PIPE_STALL_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipe_stall_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d_rs_addr   (d_rs_addr),
    .d_rt_addr   (d_rt_addr),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_is_md     (d_is_md),
    .e_wr_addr   (e_wr_addr),
    .e_tnew      (e_tnew),
    .m_wr_addr   (m_wr_addr),
    .m_tnew      (m_tnew),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .f_we        (f_we),
    .d_we        (d_we),
    .e_flush     (e_flush),
    .md_busy     (md_busy)
`ifdef PIPE_STALL_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- reference model
  // The md unit is modelled as "free from cycle md_free_at onwards": an operation
  // accepted in cycle c with latency L keeps the unit busy through cycle c+L.
  longint cyc        = 0;
  longint md_free_at = 0;
  longint sc_model   = 0;

  function automatic bit model_hazard(input int rd, input int tuse, input int wr, input int tnew);
    return (rd != 0) && (rd == wr) && (tuse < tnew);
  endfunction

  function automatic bit model_busy();
    return (cyc < md_free_at) || e_md_start;
  endfunction

  function automatic bit model_stall();
    return model_hazard(d_rs_addr, d_tuse_rs, e_wr_addr, e_tnew) ||
           model_hazard(d_rs_addr, d_tuse_rs, m_wr_addr, m_tnew) ||
           model_hazard(d_rt_addr, d_tuse_rt, e_wr_addr, e_tnew) ||
           model_hazard(d_rt_addr, d_tuse_rt, m_wr_addr, m_tnew) ||
           (d_is_md && model_busy());
  endfunction

  always @(posedge clk) begin
    assert (reset || !(e_md_start && (cyc < md_free_at)))
      else $error("illegal e_md_start while md unit busy at cycle %0d", cyc);
    if (reset) begin
      md_free_at = cyc + 1;
      sc_model   = 0;
    end else begin
      if (e_md_start && !(cyc < md_free_at))
        md_free_at = cyc + 1 + (e_md_is_div ? DIV_LAT : MULT_LAT);
      if (model_stall() && sc_model != 64'hFFFF_FFFF) sc_model++;
    end
    cyc++;
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare {f_we, d_we, e_flush, md_busy} against a required stall / busy pair.
  task automatic check_out(input string name, input bit exp_stall, input bit exp_busy);
    check(name, 32'({f_we, d_we, e_flush, md_busy}),
          32'({~exp_stall, ~exp_stall, exp_stall, exp_busy}));
  endtask

  task automatic set_idle();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_is_md = 1'b0; e_wr_addr = 5'd0; e_tnew = 2'd0; m_wr_addr = 5'd0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  // Wait for the falling edge; the caller then drives inputs for this cycle.
  task automatic next_cycle();
    @(negedge clk);
    reset = 1'b0;
    set_idle();
  endtask

  typedef struct {
    logic [4:0] rs;  logic [1:0] tu_rs;
    logic [4:0] rt;  logic [1:0] tu_rt;
    logic [4:0] ew;  logic [1:0] et;
    logic [4:0] mw;  logic [1:0] mt;
    logic       is_md;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[12];

  initial begin
    //          rs  tu  rt  tu  ew  et  mw  mt  md  stall
    vecs[0]  = '{5'd8, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b1}; // lw -> add, E
    vecs[1]  = '{5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 5'd8, 2'd1, 1'b0, 1'b1}; // beq, M tnew 1
    vecs[2]  = '{5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 5'd8, 2'd0, 1'b0, 1'b0}; // beq, M tnew 0
    vecs[3]  = '{5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0}; // $zero
    vecs[4]  = '{5'd0, 2'd3, 5'd9, 2'd0, 5'd9, 2'd1, 5'd0, 2'd0, 1'b0, 1'b1}; // rt vs E
    vecs[5]  = '{5'd0, 2'd3, 5'd9, 2'd1, 5'd0, 2'd0, 5'd9, 2'd2, 1'b0, 1'b1}; // rt vs M
    vecs[6]  = '{5'd8, 2'd2, 5'd0, 2'd3, 5'd8, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0}; // tuse == tnew
    vecs[7]  = '{5'd8, 2'd3, 5'd0, 2'd3, 5'd8, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0}; // operand unused
    vecs[8]  = '{5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0}; // address differs
    vecs[9]  = '{5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 1'b0}; // md op, unit idle
    vecs[10] = '{5'd5, 2'd2, 5'd0, 2'd3, 5'd5, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1}; // tuse 2 < tnew 3
    vecs[11] = '{5'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0, 5'd5, 2'd2, 1'b0, 1'b1}; // rt vs M, tnew 2
  end

  // ---------------------------------------------------------------- test sequence
  initial begin
    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);

    // Reset state: first cycle after reset, no hazard on the inputs.
    next_cycle();
    #1 check_out("reset_state", 1'b0, 1'b0);

    // Load-use: exactly one stall cycle, then lw has moved to M behind a bubble.
    next_cycle();
    d_rs_addr = 5'd8; d_tuse_rs = 2'd1; e_wr_addr = 5'd8; e_tnew = 2'd2;
    #1 check_out("load_use_stall", 1'b1, 1'b0);
    next_cycle();
    d_rs_addr = 5'd8; d_tuse_rs = 2'd1; m_wr_addr = 5'd8; m_tnew = 2'd1;
    #1 check_out("load_use_release", 1'b0, 1'b0);

    // mult then mflo: stalled in the start cycle plus 5, free on the 7th.
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      d_is_md = 1'b1; e_md_start = (i == 0);
      #1 check_out($sformatf("mult_mflo_c%0d", i), i < 6, i < 6);
    end
`ifdef PIPE_STALL_STATS_EN
    #1 check("stats_after_scenarios", stall_cnt, 32'd7);
`endif

    // Single-cycle hazard table, md unit idle.
    foreach (vecs[i]) begin
      next_cycle();
      d_rs_addr = vecs[i].rs; d_tuse_rs = vecs[i].tu_rs;
      d_rt_addr = vecs[i].rt; d_tuse_rt = vecs[i].tu_rt;
      e_wr_addr = vecs[i].ew; e_tnew    = vecs[i].et;
      m_wr_addr = vecs[i].mw; m_tnew    = vecs[i].mt;
      d_is_md   = vecs[i].is_md;
      #1 check_out($sformatf("vec%0d", i), vecs[i].exp_stall, 1'b0);
    end

    // div then mflo: 11 stall cycles.
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      d_is_md = 1'b1; e_md_start = (i == 0); e_md_is_div = (i == 0);
      #1 check_out($sformatf("div_mflo_c%0d", i), i < 11, i < 11);
    end

    // Reset mid-divide when the counter reads 7 (four cycles after the start).
    next_cycle();
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    repeat (4) next_cycle();
    d_is_md = 1'b1;
    #1 check_out("div_busy_before_reset", 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    d_is_md = 1'b1;
    #1 check_out("after_reset_mid_div", 1'b0, 1'b0);

    // Randomized run against the reference model; starts only while the unit is free.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      reset       = ($urandom_range(0, 99) == 0);
      d_rs_addr   = 5'($urandom_range(0, 3));
      d_rt_addr   = 5'($urandom_range(0, 3));
      d_tuse_rs   = 2'($urandom_range(0, 3));
      d_tuse_rt   = 2'($urandom_range(0, 3));
      d_is_md     = ($urandom_range(0, 3) == 0);
      e_wr_addr   = 5'($urandom_range(0, 3));
      e_tnew      = 2'($urandom_range(0, 3));
      m_wr_addr   = 5'($urandom_range(0, 3));
      m_tnew      = 2'($urandom_range(0, 3));
      e_md_start  = !(cyc < md_free_at) && ($urandom_range(0, 7) == 0);
      e_md_is_div = 1'($urandom_range(0, 1));
      #1;
      if (!reset) begin
        check_out($sformatf("rand%0d", i), model_stall(), model_busy());
`ifdef PIPE_STALL_STATS_EN
        check($sformatf("rand_stats%0d", i), stall_cnt, 32'(sc_model));
`endif
      end
    end

`ifdef PIPE_STALL_STATS_EN
    // Saturation: preload just below the top, then stall for four cycles.
    next_cycle();
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    check("stats_preload", stall_cnt, 32'hFFFF_FFFD);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      d_rs_addr = 5'd8; d_tuse_rs = 2'd0; e_wr_addr = 5'd8; e_tnew = 2'd1;
      #1 check($sformatf("stats_sat%0d", i), stall_cnt,
               (i == 0) ? 32'hFFFF_FFFD : (i == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end
    next_cycle();
    #1 check("stats_saturated", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
